// File: rtl/decode_stage_sp.sv
// Stack-processor decode stage: owns SP, expands 27-bit instr to 84-bit uop.
// Optional bounds check on push/pop enabled by DECODE_STACK_CHECK_EN.
package decode_sp_pkg;

  typedef struct packed {
    logic [1:0]  ld;
    logic [1:0]  st;
    logic [4:0]  aluop;
    logic [2:0]  jtype;
    logic [1:0]  stk;
    logic [15:0] ldimm;
    logic [15:0] stimm;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [6:0]  staddr;
    logic [6:0]  ldaddr;
    logic        we;
    logic [7:0]  jaddr;
  } uop_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_ERR
  } state_t;

endpackage

module decode_stage_sp
  import decode_sp_pkg::*;
#(
  parameter int SP_W    = 7,
  parameter int SP_INIT = 0,
  parameter int SP_MIN  = 0,
  parameter int SP_MAX  = 127
) (
  input  logic            system1000,
  input  logic            system1000_rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [26:0]     instr,
  input  logic            flush,
  input  logic            sp_wr,
  input  logic [SP_W-1:0] sp_wr_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [83:0]     uop,
  output logic [SP_W-1:0] sp,
  output logic            halted,
  output logic            err
);

  localparam logic [SP_W-1:0] SP_ONE =
    {{(SP_W-1){1'b0}}, 1'b1};

  state_t          state_q;
  state_t          state_d;
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_inc;
  logic [SP_W-1:0] sp_dec;
  logic            ov_q;
  uop_t            uop_q;
  uop_t            dec;
  logic [7:0]      op_hot;
  logic            is_push;
  logic            is_pop;
  logic            is_end;
  logic            at_max;
  logic            at_min;
  logic            bad;
  logic            acc;

  assign sp_inc = sp_q + SP_ONE;
  assign sp_dec = sp_q - SP_ONE;
  assign at_max = (sp_q == SP_W'(SP_MAX));
  assign at_min = (sp_q == SP_W'(SP_MIN));

  assign in_ready = (state_q == S_RUN)
                  && (!ov_q || out_ready)
                  && !flush;
  assign acc = in_valid && in_ready;

`ifdef DECODE_STACK_CHECK_EN
  assign bad = (is_push && at_max)
             || (is_pop && at_min);
  assign err = (state_q == S_ERR);
`else
  logic unused_bounds;
  assign unused_bounds = ^{at_max, at_min};
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  assign op_hot = 8'b1 << instr[26:24];

  always_comb begin
    dec     = '0;
    is_push = 1'b0;
    is_pop  = 1'b0;
    is_end  = 1'b0;
    unique case (1'b1)
      op_hot[0]: begin
        dec.ld    = 2'd3;
        dec.aluop = instr[23:19];
        dec.ra    = instr[18:14];
        dec.rb    = instr[13:9];
        dec.rd    = instr[8:4];
      end
      op_hot[1]: begin
        dec.jtype = instr[23:21];
        dec.jaddr = instr[20:13];
      end
      op_hot[2]: begin
        dec.rd = instr[6:2];
        if (instr[23]) begin
          dec.ld    = 2'd1;
          dec.ldimm = instr[22:7];
        end else begin
          dec.ld     = 2'd2;
          dec.ldaddr = instr[22:16];
        end
      end
      op_hot[3]: begin
        dec.we     = 1'b1;
        dec.staddr = instr[6:0];
        if (instr[23]) begin
          dec.st    = 2'd1;
          dec.stimm = instr[22:7];
        end else begin
          dec.st = 2'd2;
          dec.ra = instr[22:18];
        end
      end
      op_hot[4]: begin
        dec.st     = 2'd2;
        dec.stk    = 2'd1;
        dec.ra     = instr[23:19];
        dec.staddr = sp_inc;
        dec.we     = 1'b1;
        is_push    = 1'b1;
      end
      op_hot[5]: begin
        dec.ld     = 2'd2;
        dec.stk    = 2'd2;
        dec.rd     = instr[23:19];
        dec.ldaddr = sp_q;
        is_pop     = 1'b1;
      end
      op_hot[6]: begin
        dec.jtype = 3'd2;
        is_end    = 1'b1;
      end
      op_hot[7]: ;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (acc && bad)         state_d = S_ERR;
        else if (acc && is_end) state_d = S_HALT;
      end
      S_HALT: if (flush) state_d = S_RUN;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) state_q <= S_RUN;
    else                  state_q <= state_d;
  end

  // sp_wr wins over the push/pop step; decode already used the old sp
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      sp_q <= SP_W'(SP_INIT);
    end else if (sp_wr) begin
      sp_q <= sp_wr_val;
    end else if (acc && !bad) begin
      if (is_push)     sp_q <= sp_inc;
      else if (is_pop) sp_q <= sp_dec;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      ov_q  <= 1'b0;
      uop_q <= '0;
    end else if (flush) begin
      ov_q  <= 1'b0;
      uop_q <= '0;
    end else if (acc) begin
      ov_q  <= 1'b1;
      uop_q <= dec;
    end else if (out_ready) begin
      ov_q  <= 1'b0;
    end
  end

  assign out_valid = ov_q;
  assign uop       = uop_q;
  assign sp        = sp_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_decode_stage_sp.sv
// Directed bench for decode_stage_sp: decode table plus stall,
// halt/flush, sp_wr, reset and stack-bound sequences.
module tb_decode_stage_sp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] instr;
  logic        flush;
  logic        sp_wr;
  logic [6:0]  sp_wr_val;
  logic        out_valid;
  logic        out_ready;
  logic [83:0] uop;
  logic [6:0]  sp;
  logic        halted;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage_sp #(
    .SP_W(7), .SP_INIT(0), .SP_MIN(0), .SP_MAX(127)
  ) dut (
    .system1000(clk),
    .system1000_rstn(rstn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr(instr),
    .flush(flush),
    .sp_wr(sp_wr),
    .sp_wr_val(sp_wr_val),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .uop(uop),
    .sp(sp),
    .halted(halted),
    .err(err)
  );

  typedef struct {
    logic [26:0] instr;
    logic [83:0] u;
    logic [6:0]  sp;
  } vec_t;

  vec_t v[12];

  function automatic logic [83:0] mk(
    input logic [1:0] ld, input logic [1:0] st,
    input logic [4:0] al, input logic [2:0] jt,
    input logic [1:0] sk, input logic [15:0] li,
    input logic [15:0] si, input logic [4:0] ra,
    input logic [4:0] rb, input logic [4:0] rd,
    input logic [6:0] sa, input logic [6:0] la,
    input logic we, input logic [7:0] ja);
    return {ld, st, al, jt, sk, li, si,
            ra, rb, rd, sa, la, we, ja};
  endfunction

  function automatic logic [83:0] u_push(
    input logic [4:0] ra, input logic [6:0] sa);
    return mk('0, 2'd2, '0, '0, 2'd1, '0, '0,
              ra, '0, '0, sa, '0, 1'b1, '0);
  endfunction

  function automatic logic [83:0] u_pop(
    input logic [4:0] rd, input logic [6:0] la);
    return mk(2'd2, '0, '0, '0, 2'd2, '0, '0,
              '0, '0, rd, '0, la, 1'b0, '0);
  endfunction

  task automatic chk_u(input string nm,
    input logic [83:0] a, input logic [83:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic chk_s(input string nm,
    input logic [6:0] a, input logic [6:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, a, e);
    end
  endtask

  task automatic chk_b(input string nm,
    input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] exp_sp;
  logic       exp_err;
  logic       exp_rdy;

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    flush     = 1'b0;
    sp_wr     = 1'b0;
    sp_wr_val = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_b("rst_ov", out_valid, 1'b0);
    chk_u("rst_uop", uop, '0);
    chk_s("rst_sp", sp, 7'd0);
    chk_b("rst_halt", halted, 1'b0);
    chk_b("rst_err", err, 1'b0);
    chk_b("rst_rdy", in_ready, 1'b1);
    rstn = 1'b1;
    tick();

    v[0]  = '{27'h4180000, u_push(5'd3, 7'd1), 7'd1};
    v[1]  = '{27'h4080000, u_push(5'd1, 7'd2), 7'd2};
    v[2]  = '{27'h4100000, u_push(5'd2, 7'd3), 7'd3};
    v[3]  = '{27'h5200000, u_pop(5'd4, 7'd3), 7'd2};
    v[4]  = '{27'h5280000, u_pop(5'd5, 7'd2), 7'd1};
    v[5]  = '{{3'd0, 5'h15, 5'd1, 5'd2, 5'd3, 4'h0},
              mk(2'd3, '0, 5'h15, '0, '0, '0, '0,
                 5'd1, 5'd2, 5'd3, '0, '0, 1'b0, '0),
              7'd1};
    v[6]  = '{{3'd1, 3'd5, 8'hF3, 13'h0},
              mk('0, '0, '0, 3'd5, '0, '0, '0,
                 '0, '0, '0, '0, '0, 1'b0, 8'hF3),
              7'd1};
    v[7]  = '{{3'd2, 1'b1, 16'h8001, 5'd5, 2'b0},
              mk(2'd1, '0, '0, '0, '0, 16'h8001, '0,
                 '0, '0, 5'd5, '0, '0, 1'b0, '0),
              7'd1};
    v[8]  = '{{3'd2, 1'b0, 7'h2A, 9'h0, 5'd7, 2'b0},
              mk(2'd2, '0, '0, '0, '0, '0, '0,
                 '0, '0, 5'd7, '0, 7'h2A, 1'b0, '0),
              7'd1};
    v[9]  = '{{3'd3, 1'b1, 16'hBEEF, 7'h11},
              mk('0, 2'd1, '0, '0, '0, '0, 16'hBEEF,
                 '0, '0, '0, 7'h11, '0, 1'b1, '0),
              7'd1};
    v[10] = '{{3'd3, 1'b0, 5'd9, 11'h0, 7'h22},
              mk('0, 2'd2, '0, '0, '0, '0, '0,
                 5'd9, '0, '0, 7'h22, '0, 1'b1, '0),
              7'd1};
    v[11] = '{{3'd7, 24'hFFFFFF}, '0, 7'd1};

    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      instr    = v[i].instr;
      @(negedge clk);
      chk_b($sformatf("v%0d_rdy", i), in_ready, 1'b1);
      tick();
      chk_b($sformatf("v%0d_ov", i), out_valid, 1'b1);
      chk_u($sformatf("v%0d_uop", i), uop, v[i].u);
      chk_s($sformatf("v%0d_sp", i), sp, v[i].sp);
    end
    in_valid = 1'b0;
    tick();
    chk_b("drain_ov", out_valid, 1'b0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 27'h4300000;
    tick();
    chk_b("stall_ov", out_valid, 1'b1);
    chk_u("stall_uop0", uop, u_push(5'd6, 7'd2));
    chk_s("stall_sp0", sp, 7'd2);
    instr = 27'h5300000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_b("stall_rdy", in_ready, 1'b0);
      tick();
      chk_b("stall_hold_ov", out_valid, 1'b1);
      chk_u("stall_hold_uop", uop, u_push(5'd6, 7'd2));
      chk_s("stall_hold_sp", sp, 7'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_b("stall_rel_rdy", in_ready, 1'b1);
    tick();
    chk_u("stall_rel_uop", uop, u_pop(5'd6, 7'd2));
    chk_s("stall_rel_sp", sp, 7'd1);
    in_valid = 1'b0;
    tick();
    chk_b("stall_drain_ov", out_valid, 1'b0);

    in_valid = 1'b1;
    instr    = 27'h6000000;
    tick();
    chk_u("end_uop", uop,
          mk('0, '0, '0, 3'd2, '0, '0, '0,
             '0, '0, '0, '0, '0, 1'b0, '0));
    chk_b("end_ov", out_valid, 1'b1);
    chk_b("end_halt", halted, 1'b1);
    instr = 27'h7000000;
    @(negedge clk);
    chk_b("halt_rdy", in_ready, 1'b0);
    tick();
    chk_b("halt_ov_clr", out_valid, 1'b0);
    chk_b("halt_stay", halted, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    chk_b("flush_rdy", in_ready, 1'b0);
    tick();
    flush = 1'b0;
    chk_b("flush_halt", halted, 1'b0);
    chk_b("flush_ov", out_valid, 1'b0);
    chk_s("flush_sp", sp, 7'd1);
    @(negedge clk);
    chk_b("flush_rdy_after", in_ready, 1'b1);
    tick();
    chk_b("nop_ov", out_valid, 1'b1);
    chk_u("nop_uop", uop, '0);
    in_valid = 1'b0;
    tick();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 27'h4080000;
    tick();
    chk_b("held_ov", out_valid, 1'b1);
    chk_s("held_sp", sp, 7'd2);
    flush     = 1'b1;
    sp_wr     = 1'b1;
    sp_wr_val = 7'h50;
    tick();
    flush    = 1'b0;
    sp_wr    = 1'b0;
    in_valid = 1'b0;
    chk_b("fl_wr_ov", out_valid, 1'b0);
    chk_u("fl_wr_uop", uop, '0);
    chk_s("fl_wr_sp", sp, 7'h50);

    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 27'h4080000;
    sp_wr     = 1'b1;
    sp_wr_val = 7'h10;
    tick();
    sp_wr    = 1'b0;
    in_valid = 1'b0;
    chk_u("spwr_uop", uop, u_push(5'd1, 7'h51));
    chk_s("spwr_sp", sp, 7'h10);
    tick();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_b("mid_ov", out_valid, 1'b1);
    chk_s("mid_sp", sp, 7'h11);
    #2 rstn = 1'b0;
    #1;
    chk_b("mid_rst_ov", out_valid, 1'b0);
    chk_u("mid_rst_uop", uop, '0);
    chk_s("mid_rst_sp", sp, 7'd0);
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    tick();

    sp_wr     = 1'b1;
    sp_wr_val = 7'd125;
    tick();
    sp_wr = 1'b0;
    chk_s("ovf_pre_sp", sp, 7'd125);
    in_valid = 1'b1;
    instr    = 27'h4080000;
    tick();
    chk_u("ovf_p1", uop, u_push(5'd1, 7'd126));
    chk_s("ovf_p1_sp", sp, 7'd126);
    tick();
    chk_u("ovf_p2", uop, u_push(5'd1, 7'd127));
    chk_s("ovf_p2_sp", sp, 7'd127);
    tick();
    in_valid = 1'b0;
`ifdef DECODE_STACK_CHECK_EN
    exp_sp  = 7'd127;
    exp_err = 1'b1;
    exp_rdy = 1'b0;
`else
    exp_sp  = 7'd0;
    exp_err = 1'b0;
    exp_rdy = 1'b1;
`endif
    chk_b("ovf_p3_ov", out_valid, 1'b1);
    chk_u("ovf_p3", uop, u_push(5'd1, 7'd0));
    chk_s("ovf_p3_sp", sp, exp_sp);
    chk_b("ovf_err", err, exp_err);
    @(negedge clk);
    chk_b("ovf_rdy", in_ready, exp_rdy);
    tick();
    chk_b("ovf_drain_ov", out_valid, 1'b0);
    chk_b("ovf_err_hold", err, exp_err);

    rstn = 1'b0;
    #1;
    chk_b("unf_rst_err", err, 1'b0);
    rstn = 1'b1;
    in_valid = 1'b1;
    instr    = 27'h5100000;
    tick();
    in_valid = 1'b0;
`ifdef DECODE_STACK_CHECK_EN
    exp_sp = 7'd0;
`else
    exp_sp = 7'd127;
`endif
    chk_u("unf_uop", uop, u_pop(5'd2, 7'd0));
    chk_s("unf_sp", sp, exp_sp);
    chk_b("unf_err", err, exp_err);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_sp.md
Name: decode_stage_sp

Overview:
- Registered, handshaked instruction-decode stage for the stack processor.
- Owns the stack pointer instead of taking it as an input.
- Expands one 27-bit instruction per accepted transfer into the 84-bit micro-op bus consumed by execute/memory.
- Adds a back-pressure pipeline register, a halt state on end-of-program, flush and SP-restore hooks, and parametrised stack bounds.

Parameters:
- SP_W, 7, stack pointer / data-memory address width; must be 7 for the 27-bit encoding.
- SP_INIT, 0, stack pointer value after reset.
- SP_MIN, 0, lowest legal SP; a pop with SP==SP_MIN underflows.
- SP_MAX, 127, highest legal SP; a push with SP==SP_MAX overflows.

Ports:
- system1000, in, 1, clock, rising edge.
- system1000_rstn, in, 1, asynchronous active-low reset.
- in_valid, in, 1, instr is valid.
- in_ready, out, 1, stage accepts instr this cycle.
- instr, in, 27, instruction word.
- flush, in, 1, discard held micro-op and clear halt.
- sp_wr, in, 1, load SP from sp_wr_val.
- sp_wr_val, in, SP_W, restore value for SP.
- out_valid, out, 1, uop is valid.
- out_ready, in, 1, downstream consumes uop.
- uop, out, 84, micro-op, MSB first:
  - ld[2], st[2], aluop[5], jtype[3], stk[2]
  - ldimm[16], stimm[16]
  - ra[5], rb[5], rd[5]
  - staddr[7], ldaddr[7], we[1], jaddr[8, signed]
- sp, out, SP_W, current committed SP.
- halted, out, 1, state is HALT.
- err, out, 1, state is ERR; tied 0 without the optional feature.

Behaviour:
- Reset values (async, rstn low):
  - state=RUN, sp=SP_INIT, out_valid=0, uop=0, halted=0, err=0.
  - Release is synchronous to the next system1000 edge.
- States:
  - RUN: normal operation.
  - HALT: entered when an opcode-6 instruction is accepted; in_ready=0. Exit only via flush (to RUN) or reset.
  - ERR: entered only under the optional feature; in_ready=0. Exit only via reset.
- in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready. On accept, uop is registered next cycle and out_valid=1: latency 1 cycle.
- uop/out_valid hold stable while out_valid && !out_ready. Full throughput: one instruction per cycle when out_ready=1.
- out_valid clears when consumed and no new accept occurs in the same cycle.
- Decode by instr[26:24]; all uop fields not listed are 0:
  - 0: ld=3, aluop=[23:19], ra=[18:14], rb=[13:9], rd=[8:4].
  - 1: jtype=[23:21], jaddr=[20:13].
  - 2: rd=[6:2]; if [23]: ld=1, ldimm=[22:7]; else ld=2, ldaddr=[22:16].
  - 3: we=1, staddr=[6:0]; if [23]: st=1, stimm=[22:7]; else st=2, ra=[22:18].
  - 4 push: st=2, stk=1, ra=[23:19], staddr=sp+1 (mod 2^SP_W), we=1; sp<=sp+1.
  - 5 pop: ld=2, stk=2, rd=[23:19], ldaddr=sp; sp<=sp-1.
  - 6 end: jtype=2; state<=HALT.
  - 7: uop all zero (no-op); out_valid still set.
- SP arithmetic is unsigned, wrapping modulo 2^SP_W. sp updates on the accept edge, so back-to-back push/pop see the updated value.
- flush (priority over accept): out_valid<=0, HALT->RUN, no accept that cycle, sp unchanged.
- sp_wr: sp<=sp_wr_val, priority over a same-cycle push/pop update; the instruction itself is still accepted and decoded with the old sp.
- flush and sp_wr in the same cycle: both take effect.
- Reset mid-transfer discards the held uop.

Optional Feature:
- Macro DECODE_STACK_CHECK_EN.
- Defined:
  - A push accepted with sp==SP_MAX, or a pop with sp==SP_MIN, is still decoded and emitted.
  - sp is not updated; state<=ERR; err=1 from the next cycle.
- Undefined: no bounds checking; sp wraps; err tied to 0; ERR unreachable.

Test Plan:
- Reset, sp=0; push r3 (instr=27'h4180000) with out_ready=1 -> next cycle out_valid=1, stk=1, ra=3, staddr=1, we=1; sp=1.
- Three pushes then two pops with out_ready=1:
  - push staddr = 1, 2, 3.
  - pop ldaddr = 3, 2.
  - final sp=1.
- out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 after the first accept; uop stable; no sp change until released.
- Load imm (opcode 2, [23]=1, [22:7]=16'h8001, rd=5) -> ld=1, ldimm=16'h8001, rd=5.
- End (27'h6000000) -> jtype=2, halted=1, in_ready=0; flush -> halted=0, out_valid=0, in_ready=1.
- With DECODE_STACK_CHECK_EN, SP_MAX=2, three pushes -> third uop emitted, err=1, sp=2, in_ready=0 until reset. Without the macro, the same stimulus gives sp=3 and err=0.
